// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for a single-port pipelined
// data memory (64 x 32, word = addr[7:2]); port 0 = CPU MEM, port 1 = aux.
// Ports: clk, rst (async, active-high);
//   pN_req/pN_we/pN_addr/pN_wdata -> pN_gnt (comb), pN_rvalid/pN_rdata;
//   mem_addr/mem_wdata/mem_read/mem_write (registered), mem_rdata (in).
// Optional macro DMEM_ARB_MISALIGN_TRAP_EN adds p0_err/p1_err: misaligned
// requests are granted but issue no memory command and pulse err instead.
module dmem_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  output logic              p0_err,
  output logic              p1_err,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              last_gnt;
  logic              acc;
  logic              sel;
  logic              sel_we;
  logic              bad;
  logic              cmd_rd;
  logic              cmd_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // read tag: stage q lines up with the command cycle,
  // stage qq with the cycle the memory returns data
  logic rd_q;
  logic rd_qq;
  logic own_q;
  logic own_qq;

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    unique case (1'b1)
      p0_req & p1_req: begin
        // last_gnt = 1 means port 1 had the previous slot
        if ((PRIORITY_MODE == 1) || last_gnt) p0_gnt = 1'b1;
        else                                  p1_gnt = 1'b1;
      end
      p0_req & ~p1_req: p0_gnt = 1'b1;
      ~p0_req & p1_req: p1_gnt = 1'b1;
      default: ;
    endcase
  end

  assign acc       = p0_gnt | p1_gnt;
  assign sel       = p1_gnt;
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  assign bad = |sel_addr[1:0];
`else
  assign bad = 1'b0;
`endif

  assign cmd_rd = acc & ~sel_we & ~bad;
  assign cmd_wr = acc &  sel_we & ~bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      last_gnt  <= 1'b1;
      rd_q      <= 1'b0;
      rd_qq     <= 1'b0;
      own_q     <= 1'b0;
      own_qq    <= 1'b0;
    end else begin
      mem_read  <= cmd_rd;
      mem_write <= cmd_wr;
      if (acc) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        last_gnt  <= sel;
      end
      rd_q   <= cmd_rd;
      own_q  <= sel;
      rd_qq  <= rd_q;
      own_qq <= own_q;
    end
  end

  assign p0_rvalid = rd_qq & ~own_qq;
  assign p1_rvalid = rd_qq &  own_qq;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  logic err_q;
  logic err_qq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      err_qq <= 1'b0;
    end else begin
      err_q  <= acc & bad;
      err_qq <= err_q;
    end
  end

  // owner field is shared with the read tag
  assign p0_err = err_qq & ~own_qq;
  assign p1_err = err_qq &  own_qq;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random traffic on two dmem_arbiter instances
// (k=0 round-robin, k=1 fixed priority), each with its own memory model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        rq    [2][2];
  logic        wr    [2][2];
  logic [31:0] ad    [2][2];
  logic [31:0] wd    [2][2];
  logic        gnt   [2][2];
  logic        rv    [2][2];
  logic [31:0] rd    [2][2];
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  logic        er    [2][2];
`endif
  logic [31:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [31:0] mrdata[2];
  logic        mrd   [2];
  logic        mwr   [2];
  bit   [31:0] mem   [2][64];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .PRIORITY_MODE(g),
      .ADDR_W(32),
      .DATA_W(32)
    ) dut (
      .clk(clk),
      .rst(rst),
      .p0_req(rq[g][0]),
      .p0_we(wr[g][0]),
      .p0_addr(ad[g][0]),
      .p0_wdata(wd[g][0]),
      .p0_gnt(gnt[g][0]),
      .p0_rvalid(rv[g][0]),
      .p0_rdata(rd[g][0]),
      .p1_req(rq[g][1]),
      .p1_we(wr[g][1]),
      .p1_addr(ad[g][1]),
      .p1_wdata(wd[g][1]),
      .p1_gnt(gnt[g][1]),
      .p1_rvalid(rv[g][1]),
      .p1_rdata(rd[g][1]),
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
      .p0_err(er[g][0]),
      .p1_err(er[g][1]),
`endif
      .mem_addr(maddr[g]),
      .mem_wdata(mwd[g]),
      .mem_read(mrd[g]),
      .mem_write(mwr[g]),
      .mem_rdata(mrdata[g])
    );
  end

  // pipelined memory: write at falling edge, read sampled at rising edge
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (mwr[k]) mem[k][maddr[k][7:2]] <= mwd[k];

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (mrd[k]) mrdata[k] <= mem[k][maddr[k][7:2]];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          inst;
    int          due;
    int          port;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        keep[$];
  bit   [31:0] sh    [2][64];
  int          last  [2];
  logic        exp_rd[2];
  logic        exp_wr[2];
  logic [31:0] exp_a [2];
  logic [31:0] exp_d [2];
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int          w;
      bit          hit;
      bit          mis;
      rsp_t        r;
      logic [31:0] a;
      if (rst) begin
        chk($sformatf("rst_mrd%0d", k), mrd[k], 0);
        chk($sformatf("rst_mwr%0d", k), mwr[k], 0);
        chk($sformatf("rst_maddr%0d", k), maddr[k], 0);
        chk($sformatf("rst_mwd%0d", k), mwd[k], 0);
        chk($sformatf("rst_rv0_%0d", k), rv[k][0], 0);
        chk($sformatf("rst_rv1_%0d", k), rv[k][1], 0);
        exp_rd[k] = 0;
        exp_wr[k] = 0;
        exp_a[k]  = 0;
        exp_d[k]  = 0;
        last[k]   = 1;
        keep = {};
        foreach (q[i]) if (q[i].inst != k) keep.push_back(q[i]);
        q = keep;
        continue;
      end
      if (exp_wr[k]) sh[k][exp_a[k][7:2]] = exp_d[k];
      chk($sformatf("mrd%0d", k), mrd[k], exp_rd[k]);
      chk($sformatf("mwr%0d", k), mwr[k], exp_wr[k]);
      chk($sformatf("maddr%0d", k), maddr[k], exp_a[k]);
      chk($sformatf("mwd%0d", k), mwd[k], exp_d[k]);
      hit = 0;
      r   = '{0, 0, 0, 0, 0};
      foreach (q[i])
        if (q[i].inst == k && q[i].due == cyc) begin
          hit = 1;
          r   = q[i];
        end
      for (int p = 0; p < 2; p++) begin
        bit v;
        v = hit && !r.err && r.port == p;
        chk($sformatf("rv%0d_%0d", p, k), rv[k][p], v);
        if (v) chk($sformatf("rdata%0d_%0d", p, k), rd[k][p], r.data);
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        chk($sformatf("err%0d_%0d", p, k), er[k][p],
            hit && r.err && r.port == p);
`endif
      end
      // arbitration from the rules: a lone requester wins; on a conflict
      // fixed mode picks port 0, round-robin the port not served last
      w = -1;
      if (rq[k][0] && rq[k][1]) w = (k == 1) ? 0 : 1 - last[k];
      else if (rq[k][0])        w = 0;
      else if (rq[k][1])        w = 1;
      chk($sformatf("gnt0_%0d", k), gnt[k][0], w == 0);
      chk($sformatf("gnt1_%0d", k), gnt[k][1], w == 1);
      exp_rd[k] = 0;
      exp_wr[k] = 0;
      if (w >= 0) begin
        last[k]  = w;
        a        = ad[k][w];
        exp_a[k] = a;
        exp_d[k] = wd[k][w];
        mis      = 0;
`ifdef DMEM_ARB_MISALIGN_TRAP_EN
        mis      = a[1:0] != 2'b00;
`endif
        if (mis)
          q.push_back('{k, cyc + 2, w, 1, 0});
        else if (wr[k][w])
          exp_wr[k] = 1;
        else begin
          exp_rd[k] = 1;
          q.push_back('{k, cyc + 2, w, 0, sh[k][a[7:2]]});
        end
      end
    end
    keep = {};
    foreach (q[i]) if (q[i].due > cyc) keep.push_back(q[i]);
    q = keep;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      rq[k][p] = r;
      wr[k][p] = w;
      ad[k][p] = a;
      wd[k][p] = d;
    end
  endtask

  // one request from a lone port, granted in the same cycle
  task automatic issue(input int p, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    drive(1 - p, 0, 0, 0, 0);
    drive(p, 1, w, a, d);
    at_neg();
    for (int k = 0; k < 2; k++)
      chk($sformatf("issue_gnt%0d_%0d", p, k), gnt[k][p], 1);
    tick();
    drive(p, 0, 0, 0, 0);
  endtask

  // called in the command cycle right after issue() of a read
  task automatic expect_rd(input int p, input logic [31:0] d);
    at_neg();
    for (int k = 0; k < 2; k++) chk("lit_cmd_rd", mrd[k], 1);
    tick();
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lit_rv%0d", p), rv[k][p], 1);
      chk($sformatf("lit_rv%0d", 1 - p), rv[k][1-p], 0);
      chk($sformatf("lit_rdata%0d", p), rd[k][p], d);
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      at_neg();
      tick();
    end
  endtask

  bit took[2][2];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        rq[k][p] = 0;
        wr[k][p] = 0;
        ad[k][p] = 0;
        wd[k][p] = 0;
      end
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("lit_rst_mrd", mrd[k], 0);
      chk("lit_rst_rv0", rv[k][0], 0);
    end
    tick();
    rst = 0;
    idle(1);

    // write then read the same word back-to-back
    issue(0, 1, 32'h10, 32'hDEAD_BEEF);
    issue(0, 0, 32'h10, 32'h0);
    expect_rd(0, 32'hDEAD_BEEF);

    // preload via port 1 (also leaves port 1 as last served)
    issue(1, 1, 32'h04, 32'h1111_1111);
    issue(1, 1, 32'h08, 32'h2222_2222);
    idle(1);

    // both ports read continuously
    drive(0, 1, 0, 32'h04, 0);
    drive(1, 1, 0, 32'h08, 0);
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk("rr_gnt0", gnt[0][0], (i % 2) == 0);
      chk("rr_gnt1", gnt[0][1], (i % 2) == 1);
      chk("fx_gnt0", gnt[1][0], 1);
      chk("fx_gnt1", gnt[1][1], 0);
      if (i >= 2) begin
        chk("rr_rv0", rv[0][0], (i % 2) == 0);
        chk("rr_rv1", rv[0][1], (i % 2) == 1);
        if (i % 2 == 0) chk("rr_rd0", rd[0][0], 32'h1111_1111);
        else            chk("rr_rd1", rd[0][1], 32'h2222_2222);
        chk("fx_rv0", rv[1][0], 1);
        chk("fx_rd0", rd[1][0], 32'h1111_1111);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    at_neg();
    for (int k = 0; k < 2; k++) chk("drop_gnt1", gnt[k][1], 1);
    tick();
    drive(1, 0, 0, 0, 0);
    idle(3);

    // top word and address aliasing
    issue(1, 1, 32'hFC, 32'hA5A5_A5A5);
    issue(0, 0, 32'hFC, 32'h0);
    expect_rd(0, 32'hA5A5_A5A5);
    issue(1, 1, 32'h100, 32'h1234_5678);
    issue(0, 0, 32'h0, 32'h0);
    expect_rd(0, 32'h1234_5678);

    // reset while a read is in flight
    issue(0, 0, 32'h10, 32'h0);
    rst = 1;
    at_neg();
    for (int k = 0; k < 2; k++) chk("lit_rstf_mrd", mrd[k], 0);
    rst = 0;
    tick();
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("lit_drop_rv0", rv[k][0], 0);
      chk("lit_drop_rv1", rv[k][1], 0);
      chk("lit_drop_maddr", maddr[k], 0);
    end
    tick();
    drive(0, 1, 0, 32'h10, 0);
    drive(1, 1, 0, 32'h04, 0);
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_gnt0", gnt[k][0], 1);
      chk("post_rst_gnt1", gnt[k][1], 0);
    end
    tick();
    drive(0, 0, 0, 0, 0);
    at_neg();
    tick();
    drive(1, 0, 0, 0, 0);
    idle(3);

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
    issue(0, 1, 32'h13, 32'hBAD0_BAD0);
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("trap_mwr", mwr[k], 0);
      chk("trap_mrd", mrd[k], 0);
    end
    tick();
    at_neg();
    for (int k = 0; k < 2; k++) begin
      chk("trap_err0", er[k][0], 1);
      chk("trap_err1", er[k][1], 0);
      chk("trap_rv0", rv[k][0], 0);
    end
    tick();
    at_neg();
    for (int k = 0; k < 2; k++) chk("trap_err_end", er[k][0], 0);
    tick();
    issue(0, 0, 32'h10, 32'h0);
    expect_rd(0, 32'hDEAD_BEEF);
`endif

    // random traffic; requesters hold until granted, sometimes give up
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++)
          took[k][p] = rq[k][p] && gnt[k][p];
      tick();
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          if (took[k][p] || !rq[k][p]) begin
            if ($urandom_range(0, 99) < 65) begin
              logic [31:0] a;
              a = ($urandom & 32'hFFFF_FF00)
                | (32'($urandom_range(0, 15)) << 2);
              if ($urandom_range(0, 7) == 0)
                a[1:0] = 2'($urandom_range(1, 3));
              rq[k][p] = 1;
              wr[k][p] = 1'($urandom_range(0, 1));
              ad[k][p] = a;
              wd[k][p] = $urandom;
            end else
              rq[k][p] = 0;
          end else if ($urandom_range(0, 15) == 0)
            rq[k][p] = 0;
        end
    end
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) rq[k][p] = 0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
